// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int CNT_WIDTH  = 4;   // holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_load_align.sv
// Load lane selection and sign/zero extension (purely combinational).
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  size_e       i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  // Pick the addressed lane(s) and extend to 32 bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_data = '0;
    case (i_size)
      SIZE_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      SIZE_WORD: o_data = i_word;
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: one outstanding byte/half/word access with a
// fixed WAIT_CYCLES latency and a valid/ready response.
// Optional macro DMEM_MISALIGN_CHECK_EN: flag misaligned half/word accesses
// as errors instead of silently aligning the address.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_WIDTH'(WAIT_CYCLES - 1) : '0;

  state_e                r_state, w_next_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_we, r_unsigned;
  size_e                 r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                    w_accept, w_enter_resp, w_in_idle;
  logic                    w_acc_we, w_acc_unsigned, w_err, w_misalign;
  size_e                   w_acc_size;
  logic [ADDR_WIDTH-1:0]   w_acc_addr, w_addr_eff;
  logic [31:0]             w_acc_wdata, w_lane_data, w_rd_word, w_load_data;
  logic [WORD_BYTES-1:0]   w_strb;
  logic [ADDR_WIDTH-3:0]   w_idx;

  assign w_in_idle = (r_state == ST_IDLE);
  assign req_ready = w_in_idle;
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Nothing is accepted while reset is held, so a zero-latency store cannot slip through.
  assign w_accept     = req_valid && w_in_idle && reset_n;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == '0));

  // With zero wait cycles the access happens on the accept edge, so use the live request.
  assign w_acc_we       = w_in_idle ? req_we            : r_we;
  assign w_acc_size     = w_in_idle ? size_e'(req_size) : r_size;
  assign w_acc_unsigned = w_in_idle ? req_unsigned      : r_unsigned;
  assign w_acc_addr     = w_in_idle ? req_addr          : r_addr;
  assign w_acc_wdata    = w_in_idle ? req_wdata         : r_wdata;

  assign w_misalign = ((w_acc_size == SIZE_HALF) && w_acc_addr[0]) ||
                      ((w_acc_size == SIZE_WORD) && (w_acc_addr[1:0] != 2'b00));

  // Error detection and effective address (misalignment either flagged or masked off).
  always_comb begin
    w_addr_eff = w_acc_addr;
`ifdef DMEM_MISALIGN_CHECK_EN
    w_err = (w_acc_size == SIZE_RSVD) || w_misalign;
`else
    w_err = (w_acc_size == SIZE_RSVD);
    if (w_acc_size == SIZE_HALF) w_addr_eff[0]   = 1'b0;
    if (w_acc_size == SIZE_WORD) w_addr_eff[1:0] = 2'b00;
`endif
  end

  assign w_idx     = w_addr_eff[ADDR_WIDTH-1:2];
  assign w_rd_word = r_mem[w_idx];

  // Byte-lane write strobes and lane-replicated store data, little-endian.
  always_comb begin
    w_strb      = '0;
    w_lane_data = w_acc_wdata;
    case (w_acc_size)
      SIZE_BYTE: begin
        w_strb      = WORD_BYTES'(1) << w_addr_eff[1:0];
        w_lane_data = {4{w_acc_wdata[7:0]}};
      end
      SIZE_HALF: begin
        w_strb      = w_addr_eff[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{w_acc_wdata[15:0]}};
      end
      SIZE_WORD: w_strb = 4'b1111;
      default:   w_strb = '0;
    endcase
  end

  dmem_load_align u_load_align (
    .i_word     (w_rd_word),
    .i_size     (w_acc_size),
    .i_offset   (w_addr_eff[1:0]),
    .i_unsigned (w_acc_unsigned),
    .o_data     (w_load_data)
  );

  // Next-state logic for IDLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next_state = ST_RESP;
      ST_RESP: if (rsp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Wait counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= size_e'(req_size);
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Response registers: loaded on the edge entering RESP, held until handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_acc_we || w_err) ? 32'h0 : w_load_data;
      r_err   <= w_err;
    end
  end

  // Array write on the edge entering RESP, only the strobed lanes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive reset and it maps onto RAM.
    if (w_enter_resp && w_acc_we && !w_err) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts
// each response at issue time; a monitor checks responses as they complete.
module tb_data_mem_ctrl;

  localparam int AW    = 12;
  localparam int WAITC = 2;
  localparam int MEMB  = 4096;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC), .INIT_FILE("")) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [MEMB];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        hold_low = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, returns {err, rdata}.
  function automatic logic [32:0] model(input logic we, input logic [1:0] size,
                                        input logic uns, input logic [AW-1:0] addr,
                                        input logic [31:0] wdata);
    int nb = 1 << size;
    int a = int'(addr);
    logic err = (size == 2'b11);
    logic [31:0] val = 32'h0;
    logic [31:0] tmp;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (size == 2'b01 && (a % 2) != 0) err = 1'b1;
    if (size == 2'b10 && (a % 4) != 0) err = 1'b1;
`else
    if (!err) a = a - (a % nb);
`endif
    if (err) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        tmp = wdata >> (8 * i);
        ref_mem[(a + i) % MEMB] = tmp[7:0];
      end
      return {1'b0, 32'h0};
    end
    for (int i = 0; i < nb; i++) val = val | (32'(ref_mem[(a + i) % MEMB]) << (8 * i));
    if (!uns && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
    return {1'b0, val};
  endfunction

  // Cycle counter (posedge count).
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer back-pressure: random, or held low on demand.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rsp_ready = hold_low ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: stability while held, pop and compare on handshake.
  initial begin
    logic        prev_v = 1'b0;
    int          rise = 0;
    logic [31:0] held_d = '0;
    logic        held_e = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (!prev_v) begin
          rise   = cyc;
          held_d = rsp_rdata;
          held_e = rsp_err;
        end else begin
          check("hold_rdata", rsp_rdata, held_d);
          check("hold_err", 32'(rsp_err), 32'(held_e));
        end
        check("req_ready_in_resp", 32'(req_ready), 32'h0);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_rsp: got rdata %h with empty scoreboard", rsp_rdata);
          end else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("latency", 32'(rise - e.acc + 1), 32'(WAITC + 1));
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  // Issue one request through the model and scoreboard.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata);
    int n = 0;
    logic [32:0] r;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1 after %0d cycles", n);
      req_valid = 1'b0;
      return;
    end
    r = model(we, size, uns, addr, wdata);
    e.rdata = r[31:0];
    e.err   = r[32];
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Wait for all outstanding responses to complete.
  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_vec++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    #3;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Known contents for the region exercised below, plus the top word.
    for (int w = 0; w < 64; w++) issue(1'b1, 2'b10, 1'b0, AW'(w * 4), $urandom);
    issue(1'b1, 2'b10, 1'b0, 12'hFFC, $urandom);

    // Directed word/byte/half traffic.
    issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 12'h013, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 12'h011, 32'h0000_0055);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 12'h012, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 12'h014, 32'hFFFF_FFFF);
    issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 12'hFFE, 32'h0);

    // Back-pressure: response held for five cycles.
    drain();
    hold_low = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
    end
    repeat (5) @(negedge clk);
    check("stall_still_valid", 32'(rsp_valid), 32'h1);
    hold_low = 1'b0;
    drain();

    // Reset during WAIT of a store: the store must not commit.
    @(negedge clk);
    check("pre_store_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 12'h020; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("in_wait_req_ready", 32'(req_ready), 32'h0);
    check("in_wait_rsp_valid", 32'(rsp_valid), 32'h0);
    reset_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);

    // Random traffic over the initialised region.
    for (int k = 0; k < 300; k++) begin
      logic [1:0] sz;
      sz = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
      issue(1'($urandom_range(1)), sz, 1'($urandom_range(1)),
            AW'($urandom_range(255)), $urandom);
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
